ram8_n2t: RTL

- Eight-word Hack-style RAM (nand2tetris "RAM8") and the first sequential storage stage in the chip hierarchy.
- It is built from the combinational gates below it (and/or/not/mux/dmux families) plus per-bit storage cells.
- Downstream it feeds RAM64/RAM512 composites and, through them, the data memory of the Hack CPU.
- Write is clocked; read is combinational from the currently addressed word.

---
 rtl/ram8_n2t.sv | 90 +++++++++
 1 files changed

// File: rtl/ram8_n2t.sv
// ram8_n2t - eight-word Hack-style RAM (nand2tetris RAM8).
//
// Clocked write, combinational read. The write enable is steered to a single
// word by a dmux8way of load; the read path is a mux8way tree selected by
// address. There is no write-through: during a write cycle out still shows
// the old contents and the new value appears just after the rising edge.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   reset    - synchronous active-high reset, clears all eight words
//   in       - write data (WIDTH bits)
//   load     - write enable for word[address]
//   address  - word select for both read and write (ADDR_W bits)
//   out      - contents of word[address] (WIDTH bits)
module ram8_n2t #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [WIDTH-1:0]  out
);

    // Elaboration-time guards on the parameter set; the decode and mux tree
    // below are hand-built for exactly eight words.
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("ram8_n2t: WIDTH must be in 1..32");
        end
        if (DEPTH != 8) begin : g_bad_depth
            $error("ram8_n2t: DEPTH is fixed at 8");
        end
        if (ADDR_W != $clog2(DEPTH)) begin : g_bad_addr_w
            $error("ram8_n2t: ADDR_W must equal log2(DEPTH)");
        end
    endgenerate

    logic [WIDTH-1:0] word_q [8];
    logic [WIDTH-1:0] word_d [8];
    logic [7:0]       sel_load;

    // Read-path intermediate levels of the mux8way tree.
    logic [WIDTH-1:0] mux_l1 [4];
    logic [WIDTH-1:0] mux_l2 [2];

    // dmux8way of load: exactly one word sees the enable when load is high.
    always_comb begin
        sel_load = '0;
        for (int i = 0; i < 8; i++) begin
            sel_load[i] = load & (address == ADDR_W'(i));
        end
    end

    // Next-state for each word: take in when selected, otherwise hold.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            word_d[i] = sel_load[i] ? in : word_q[i];
        end
    end

    // Reset wins over any write presented on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                word_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                word_q[i] <= word_d[i];
            end
        end
    end

    // mux8way read: address[0] picks within pairs, address[1] within
    // quads, address[2] between halves. Depends only on stored state.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            mux_l1[j] = address[0] ? word_q[2*j+1] : word_q[2*j];
        end
        for (int k = 0; k < 2; k++) begin
            mux_l2[k] = address[1] ? mux_l1[2*k+1] : mux_l1[2*k];
        end
        out = address[2] ? mux_l2[1] : mux_l2[0];
    end

endmodule
